// File: rtl/rx_sample_sched_pkg.sv
// rx_sample_sched_pkg
// Shared definitions for the receive-window scheduler: default counter
// widths, channel-select width, FSM state encoding and the channel-wrap
// helper used by the channel scan counter.
// No ports (package).

package rx_sample_sched_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int GAP_W_DEF = 8;
    localparam int CH_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SCAN  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    // Next channel in a scan: wraps to channel 0 after the last active one,
    // so a back-to-back frame needs no separate reload.
    function automatic logic [CH_W-1:0] next_sel(input logic [CH_W-1:0] cur,
                                                 input logic [CH_W-1:0] last);
        logic [CH_W-1:0] nxt;
        if (cur == last) begin
            nxt = '0;
        end else begin
            nxt = cur + CH_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rx_sample_sched_if.sv
// rx_sample_sched_if
// Bundles the configuration, trigger, FIFO status and sequencing outputs of
// the receive-window scheduler.
//   master : drives enable/trig/channels/cfg_*/fifo_full/ovr_clr,
//            observes sel/wr_en/busy/done/overrun/frame_cnt
//   slave  : the scheduler side (mirror of master)

interface rx_sample_sched_if
    import rx_sample_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);

    logic             enable;
    logic             trig;
    logic [CH_W-1:0]  channels;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_window;
    logic [GAP_W-1:0] cfg_gap;
    logic             fifo_full;
    logic             ovr_clr;

    logic [CH_W-1:0]  sel;
    logic             wr_en;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output enable, trig, channels, cfg_delay, cfg_window, cfg_gap,
               fifo_full, ovr_clr,
        input  sel, wr_en, busy, done, overrun, frame_cnt
    );

    modport slave (
        input  enable, trig, channels, cfg_delay, cfg_window, cfg_gap,
               fifo_full, ovr_clr,
        output sel, wr_en, busy, done, overrun, frame_cnt
    );

endinterface

// File: rtl/rx_sample_sched_ch_scan_cnt.sv
// ch_scan_cnt
// Loadable channel-select counter for one frame scan.
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : force sel back to channel 0 (window start or abort)
//   adv          : step to the next channel, wrapping after ch_last
//   ch_last      : index of the last active channel
//   sel          : registered channel-mux select
//   last         : sel is on the last channel of the frame

module ch_scan_cnt
    import rx_sample_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            adv,
    input  logic [CH_W-1:0] ch_last,
    output logic [CH_W-1:0] sel,
    output logic            last
);

    // start takes priority so an abort always lands on channel 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel <= '0;
        end else if (start) begin
            sel <= '0;
        end else if (adv) begin
            sel <= next_sel(sel, ch_last);
        end
    end

    assign last = (sel == ch_last);

endmodule

// File: rtl/rx_sample_sched.sv
// rx_sample_sched
// Trigger-driven receive-window scheduler. After an accepted trigger it
// waits the programmed range delay, then issues cfg_window frames, each a
// contiguous scan of channels 0..ch_last with a FIFO write enable, separated
// by cfg_gap idle clocks. Writes into a full FIFO set a sticky overrun flag.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : enable, trig, channels, cfg_delay, cfg_window, cfg_gap,
//                  fifo_full, ovr_clr in; sel, wr_en, busy, done, overrun,
//                  frame_cnt out (all outputs registered)

module rx_sample_sched
    import rx_sample_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
)(
    input  logic            clk,
    input  logic            reset_n,
    rx_sample_sched_if.slave bus
);

    sched_state_t     state, state_nxt;

    logic [CNT_W-1:0] dly_cnt,   dly_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt,   gap_cnt_nxt;
    logic [CNT_W-1:0] win_lat,   win_lat_nxt;
    logic [GAP_W-1:0] gap_lat,   gap_lat_nxt;
    logic [CH_W-1:0]  ch_lat,    ch_lat_nxt;
    logic [CNT_W-1:0] frame_q,   frame_nxt;
    logic             wr_en_q,   wr_en_nxt;
    logic             busy_q,    busy_nxt;
    logic             done_q,    done_nxt;
    logic             ovr_q,     ovr_nxt;

    logic             scan_start;
    logic             scan_adv;
    logic             scan_last;
    logic [CH_W-1:0]  sel_q;
    logic [CNT_W-1:0] frame_inc;

    assign frame_inc = frame_q + CNT_W'(1);

    // Channel counter: sel is its register, so it stays a registered output.
    ch_scan_cnt u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (scan_start),
        .adv     (scan_adv),
        .ch_last (ch_lat),
        .sel     (sel_q),
        .last    (scan_last)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
            gap_cnt <= '0;
            win_lat <= '0;
            gap_lat <= '0;
            ch_lat  <= '0;
            frame_q <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            win_lat <= win_lat_nxt;
            gap_lat <= gap_lat_nxt;
            ch_lat  <= ch_lat_nxt;
            frame_q <= frame_nxt;
            wr_en_q <= wr_en_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    // Next-state and next-output logic. The window config is only sampled
    // on an accepted trigger, so config changes or re-triggers while busy
    // have no effect. Dropping enable overrides everything else outside IDLE.
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        gap_cnt_nxt = gap_cnt;
        win_lat_nxt = win_lat;
        gap_lat_nxt = gap_lat;
        ch_lat_nxt  = ch_lat;
        frame_nxt   = frame_q;
        wr_en_nxt   = wr_en_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        scan_start  = 1'b0;
        scan_adv    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.trig && bus.enable && (bus.cfg_window != '0)) begin
                    ch_lat_nxt  = bus.channels;
                    win_lat_nxt = bus.cfg_window;
                    gap_lat_nxt = bus.cfg_gap;
                    frame_nxt   = '0;
                    busy_nxt    = 1'b1;
                    scan_start  = 1'b1;
                    if (bus.cfg_delay == '0) begin
                        state_nxt = ST_SCAN;
                        wr_en_nxt = 1'b1;
                    end else begin
                        state_nxt   = ST_DELAY;
                        dly_cnt_nxt = bus.cfg_delay;
                    end
                end
            end

            ST_DELAY: begin
                if (dly_cnt == CNT_W'(1)) begin
                    state_nxt = ST_SCAN;
                    wr_en_nxt = 1'b1;
                end else begin
                    dly_cnt_nxt = dly_cnt - CNT_W'(1);
                end
            end

            ST_SCAN: begin
                // The counter wraps to channel 0 on its own at frame end,
                // which covers the back-to-back, gap and completion cases.
                scan_adv = 1'b1;
                if (scan_last) begin
                    frame_nxt = frame_inc;
                    if (frame_inc == win_lat) begin
                        state_nxt = ST_IDLE;
                        wr_en_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (gap_lat != '0) begin
                        state_nxt   = ST_GAP;
                        wr_en_nxt   = 1'b0;
                        gap_cnt_nxt = gap_lat;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = ST_SCAN;
                    wr_en_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort: frame_cnt keeps the number of frames completed so far.
        if (!bus.enable && (state != ST_IDLE)) begin
            state_nxt  = ST_IDLE;
            wr_en_nxt  = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b0;
            frame_nxt  = frame_q;
            scan_adv   = 1'b0;
            scan_start = 1'b1;
        end
    end

    // Sticky overrun: a write into a full FIFO beats a simultaneous clear.
    always_comb begin
        ovr_nxt = ovr_q;
        if (wr_en_q && bus.fifo_full) begin
            ovr_nxt = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_nxt = 1'b0;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_rx_sample_sched.sv
// tb_rx_sample_sched
// Directed bench for rx_sample_sched. Each window's expected writes (cycle
// and channel) and done pulse are queued when the trigger is issued; a
// negedge monitor pops and compares whenever wr_en or done is seen.

module tb_rx_sample_sched;

    localparam int CNT_W = 16;
    localparam int GAP_W = 8;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
    } exp_wr_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   e;

    exp_wr_t exp_wr[$];
    int      exp_done[$];

    rx_sample_sched_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    rx_sample_sched #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Free-running clock and cycle counter used to timestamp outputs.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle trigger; returns the cycle stamp of the sampling edge.
    task automatic applyStimulus(input logic [2:0] ch, input int delay,
                                 input int window, input int gap, output int edge_cyc);
        bus.channels   = ch;
        bus.cfg_delay  = CNT_W'(delay);
        bus.cfg_window = CNT_W'(window);
        bus.cfg_gap    = GAP_W'(gap);
        bus.trig       = 1'b1;
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        bus.trig = 1'b0;
    endtask

    // Queues nframes frames of writes; first write in cycle base+first.
    task automatic pushFrames(input int base, input int first, input int ch,
                              input int gap, input int nframes);
        exp_wr_t x;
        for (int f = 0; f < nframes; f++) begin
            for (int s = 0; s <= ch; s++) begin
                x.cyc = base + first + f * (ch + 1 + gap) + s;
                x.sel = 3'(s);
                exp_wr.push_back(x);
            end
        end
    endtask

    // Monitor: compares every observed write and done pulse with the queues.
    always @(negedge clk) begin
        exp_wr_t x;
        int      d;
        if (reset_n === 1'b1) begin
            if (bus.wr_en === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_wr_en", 1, 0);
                end else begin
                    x = exp_wr.pop_front();
                    checkOutput("wr_cycle", cyc, x.cyc);
                    checkOutput("wr_sel", {29'd0, bus.sel}, {29'd0, x.sel});
                end
            end
            if (bus.done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    d = exp_done.pop_front();
                    checkOutput("done_cycle", cyc, d);
                end
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset_n        = 1'b0;
        bus.enable     = 1'b0;
        bus.trig       = 1'b0;
        bus.channels   = '0;
        bus.cfg_delay  = '0;
        bus.cfg_window = '0;
        bus.cfg_gap    = '0;
        bus.fifo_full  = 1'b0;
        bus.ovr_clr    = 1'b0;

        waitCycles(3);
        checkOutput("rst_sel", {29'd0, bus.sel}, 0);
        checkOutput("rst_wr_en", {31'd0, bus.wr_en}, 0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 0);
        checkOutput("rst_done", {31'd0, bus.done}, 0);
        checkOutput("rst_overrun", {31'd0, bus.overrun}, 0);
        checkOutput("rst_frame_cnt", {16'd0, bus.frame_cnt}, 0);
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        waitCycles(2);

        $display("[TB] window: channels=3 delay=5 gap=2 window=3");
        applyStimulus(3'd3, 5, 3, 2, e);
        pushFrames(e, 5, 3, 2, 3);
        exp_done.push_back(e + 21);
        bus.channels   = 3'd0;
        bus.cfg_delay  = 16'd1;
        bus.cfg_window = 16'd1;
        bus.cfg_gap    = 8'd0;
        waitCycles(1);
        checkOutput("a_busy_mid", {31'd0, bus.busy}, 1);
        waitCycles(22);
        checkOutput("a_frame_cnt", {16'd0, bus.frame_cnt}, 3);
        checkOutput("a_busy_end", {31'd0, bus.busy}, 0);

        $display("[TB] window: channels=0 delay=0 gap=0 window=4");
        applyStimulus(3'd0, 0, 4, 0, e);
        pushFrames(e, 0, 0, 0, 4);
        exp_done.push_back(e + 4);
        waitCycles(6);
        checkOutput("b_frame_cnt", {16'd0, bus.frame_cnt}, 4);

        $display("[TB] rejected triggers");
        applyStimulus(3'd2, 1, 0, 0, e);
        checkOutput("win0_busy", {31'd0, bus.busy}, 0);
        waitCycles(4);
        checkOutput("win0_wr_en", {31'd0, bus.wr_en}, 0);
        bus.enable = 1'b0;
        applyStimulus(3'd2, 1, 2, 0, e);
        checkOutput("dis_busy", {31'd0, bus.busy}, 0);
        waitCycles(4);
        checkOutput("dis_wr_en", {31'd0, bus.wr_en}, 0);
        bus.enable = 1'b1;
        waitCycles(1);

        $display("[TB] re-trigger while busy");
        applyStimulus(3'd1, 2, 2, 1, e);
        pushFrames(e, 2, 1, 1, 2);
        exp_done.push_back(e + 7);
        waitCycles(3);
        bus.cfg_window = 16'd5;
        bus.trig       = 1'b1;
        waitCycles(1);
        bus.trig       = 1'b0;
        waitCycles(6);
        checkOutput("rt_frame_cnt", {16'd0, bus.frame_cnt}, 2);
        checkOutput("rt_busy", {31'd0, bus.busy}, 0);

        $display("[TB] enable dropped in frame 2 of 5");
        applyStimulus(3'd1, 1, 5, 1, e);
        pushFrames(e, 1, 1, 1, 1);
        exp_wr.push_back('{cyc: e + 4, sel: 3'd0});
        waitCycles(4);
        bus.enable = 1'b0;
        waitCycles(1);
        checkOutput("ab_wr_en", {31'd0, bus.wr_en}, 0);
        checkOutput("ab_busy", {31'd0, bus.busy}, 0);
        checkOutput("ab_sel", {29'd0, bus.sel}, 0);
        waitCycles(4);
        checkOutput("ab_frame_cnt", {16'd0, bus.frame_cnt}, 1);
        bus.enable = 1'b1;
        waitCycles(1);

        $display("[TB] overrun set/clear");
        applyStimulus(3'd0, 0, 6, 0, e);
        pushFrames(e, 0, 0, 0, 6);
        exp_done.push_back(e + 6);
        bus.fifo_full = 1'b1;
        waitCycles(1);
        bus.fifo_full = 1'b0;
        checkOutput("ovr_set", {31'd0, bus.overrun}, 1);
        waitCycles(1);
        checkOutput("ovr_sticky", {31'd0, bus.overrun}, 1);
        bus.ovr_clr = 1'b1;
        waitCycles(1);
        bus.ovr_clr = 1'b0;
        checkOutput("ovr_cleared", {31'd0, bus.overrun}, 0);
        bus.ovr_clr   = 1'b1;
        bus.fifo_full = 1'b1;
        waitCycles(1);
        bus.ovr_clr   = 1'b0;
        bus.fifo_full = 1'b0;
        checkOutput("ovr_set_wins", {31'd0, bus.overrun}, 1);
        waitCycles(4);
        bus.ovr_clr = 1'b1;
        waitCycles(1);
        bus.ovr_clr = 1'b0;
        checkOutput("ovr_idle_clear", {31'd0, bus.overrun}, 0);

        $display("[TB] async reset mid-window");
        applyStimulus(3'd3, 0, 3, 0, e);
        exp_wr.push_back('{cyc: e, sel: 3'd0});
        bus.fifo_full = 1'b1;
        waitCycles(1);
        bus.fifo_full = 1'b0;
        checkOutput("ar_ovr_pre", {31'd0, bus.overrun}, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("ar_sel", {29'd0, bus.sel}, 0);
        checkOutput("ar_wr_en", {31'd0, bus.wr_en}, 0);
        checkOutput("ar_busy", {31'd0, bus.busy}, 0);
        checkOutput("ar_overrun", {31'd0, bus.overrun}, 0);
        checkOutput("ar_frame_cnt", {16'd0, bus.frame_cnt}, 0);
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(4);
        checkOutput("ar_idle_wr_en", {31'd0, bus.wr_en}, 0);

        checkOutput("wr_queue_empty", exp_wr.size(), 0);
        checkOutput("done_queue_empty", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
